// File: rtl/popcount_stream.sv
// popcount_stream: handshaked multi-cycle popcount, CHUNK_WIDTH bits per cycle, with saturating running total
module popcount_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int ACC_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          count_zeros,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DATA_WIDTH):0]   dout,
  input  logic                          total_clr,
  output logic [ACC_WIDTH-1:0]          total,
  output logic                          total_sat
);
  localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam int SW = (ACC_WIDTH > CW ? ACC_WIDTH : CW) + 1;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] word;
  logic [IW-1:0] idx;
  logic [CW-1:0] partial, chunk_cnt;
  logic [CHUNK_WIDTH-1:0] chunk;
  logic [SW-1:0] sum;
  logic hs, last, sat;
  assign in_ready = resetn && state == IDLE;
  assign chunk = word[idx*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign last = idx == IW'(NCHUNK - 1);
  assign hs = out_valid && out_ready;
  assign sum = SW'(total) + SW'(dout);
  assign sat = sum > SW'({ACC_WIDTH{1'b1}});
  always_comb begin
    chunk_cnt = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) chunk_cnt = chunk_cnt + CW'(chunk[i]);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      word      <= '0;
      idx       <= '0;
      partial   <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      total     <= '0;
      total_sat <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          word    <= count_zeros ? ~din : din;
          idx     <= '0;
          partial <= '0;
          state   <= COUNT;
        end
        COUNT: begin
          partial <= partial + chunk_cnt;
          idx     <= idx + IW'(1);
          if (last) begin
            dout      <= partial + chunk_cnt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // clear wins over accumulation, but a word delivered on the clear cycle seeds the new total
      if (total_clr) begin
        total     <= hs ? ACC_WIDTH'(dout) : '0;
        total_sat <= 1'b0;
      end else if (hs) begin
        total     <= sat ? '1 : sum[ACC_WIDTH-1:0];
        total_sat <= total_sat | sat;
      end
    end
  end
endmodule

// File: tb/tb_popcount_stream.sv
// tb_popcount_stream: scoreboard bench for popcount_stream (16-bit and 6-bit total builds)
module tb_popcount_stream;
  logic clk, resetn, in_valid, count_zeros, out_ready, total_clr;
  logic [31:0] din;
  logic in_ready, out_valid, total_sat;
  logic [5:0] dout;
  logic [15:0] total;
  logic in_ready6, out_valid6, total_sat6;
  logic [5:0] dout6, total6;
  int checks = 0, errors = 0;
  int q[$];
  int m16 = 0, m6 = 0;
  bit s16 = 0, s6 = 0;

  popcount_stream #(.DATA_WIDTH(32), .CHUNK_WIDTH(8), .ACC_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .count_zeros(count_zeros), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .total_clr(total_clr), .total(total), .total_sat(total_sat));

  popcount_stream #(.DATA_WIDTH(32), .CHUNK_WIDTH(8), .ACC_WIDTH(6)) dut6 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready6), .din(din),
    .count_zeros(count_zeros), .out_valid(out_valid6), .out_ready(out_ready), .dout(dout6),
    .total_clr(total_clr), .total(total6), .total_sat(total_sat6));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // scoreboard and running-total model, sampled 1 time unit after the falling edge
  always @(negedge clk) begin
    int e;
    bit hs;
    #1;
    if (!resetn) begin
      q.delete();
      m16 = 0; m6 = 0; s16 = 0; s6 = 0;
    end else begin
      hs = out_valid && out_ready;
      e = 0;
      if (hs) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected dout=%0d with no word outstanding", dout);
        end else begin
          e = q.pop_front();
          if (dout !== 6'(e) || dout6 !== 6'(e)) begin
            errors++;
            $display("FAIL sb_dout got=%0d/%0d exp=%0d", dout, dout6, e);
          end
        end
      end
      if (total_clr) begin
        m16 = hs ? e : 0; m6 = hs ? e : 0; s16 = 0; s6 = 0;
      end else if (hs) begin
        if (m16 + e > 65535) begin m16 = 65535; s16 = 1; end else m16 = m16 + e;
        if (m6 + e > 63) begin m6 = 63; s6 = 1; end else m6 = m6 + e;
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic cz);
    int n;
    @(negedge clk);
    din = d; count_zeros = cz; in_valid = 1;
    for (n = 0; n < 50 && !in_ready; n++) @(negedge clk);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%b exp=1", in_ready);
    end
    q.push_back(cz ? 32 - $countones(d) : $countones(d));
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; din = $urandom; count_zeros = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 100 && (q.size() != 0 || out_valid); n++) @(negedge clk);
    if (q.size() != 0 || out_valid) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d out_valid=%b exp=0/0", q.size(), out_valid);
    end
  endtask

  task automatic wait_valid();
    int n;
    for (n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL valid_timeout out_valid=%b exp=1", out_valid);
    end
  endtask

  task automatic test_reset();
    resetn = 0; in_valid = 0; din = 0; count_zeros = 0; out_ready = 0; total_clr = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 0 || out_valid !== 0 || dout !== 0 || total !== 0 || total_sat !== 0) begin
      errors++;
      $display("FAIL reset_state rdy=%b vld=%b dout=%0d tot=%0d sat=%b exp=0", in_ready, out_valid, dout, total, total_sat);
    end
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1 || in_ready6 !== 1) begin
      errors++;
      $display("FAIL reset_idle_ready got=%b/%b exp=1", in_ready, in_ready6);
    end
  endtask

  task automatic test_single();
    int n;
    out_ready = 1;
    send(32'hFFFF_FFFF, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL latency got=%0d exp=4", n);
    end
    checks++;
    if (dout !== 6'd32) begin
      errors++;
      $display("FAIL single_dout got=%0d exp=32", dout);
    end
    drain();
    checks++;
    if (total !== 16'd32) begin
      errors++;
      $display("FAIL single_total got=%0d exp=32", total);
    end
  endtask

  task automatic test_count_zeros();
    send(32'h0000_0001, 1);
    drain();
    send(32'h8000_0000, 0);
    drain();
    checks++;
    if (total !== 16'd64 || total_sat !== 0) begin
      errors++;
      $display("FAIL cz_total got=%0d sat=%b exp=64 sat=0", total, total_sat);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    send(32'h0000_000F, 0);
    wait_valid();
    din = 32'h00FF_00FF; count_zeros = 1; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1 || dout !== 6'd4 || in_ready !== 0) begin
        errors++;
        $display("FAIL hold_%0d vld=%b dout=%0d rdy=%b exp=1/4/0", i, out_valid, dout, in_ready);
      end
    end
    q.push_back(16);
    out_ready = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1 || out_valid !== 0) begin
      errors++;
      $display("FAIL post_hs rdy=%b vld=%b exp=1/0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 0;
    drain();
    checks++;
    if (total !== 16'(m16)) begin
      errors++;
      $display("FAIL bp_total got=%0d exp=%0d", total, m16);
    end
  endtask

  task automatic test_total();
    @(negedge clk); total_clr = 1;
    @(negedge clk); total_clr = 0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      send(32'hF0F0_F0F0, 0);
      drain();
    end
    checks++;
    if (total !== 16'd48) begin
      errors++;
      $display("FAIL total_48 got=%0d exp=48", total);
    end
    out_ready = 0;
    send(32'hF0F0_F0F0, 0);
    wait_valid();
    out_ready = 1; total_clr = 1;
    @(negedge clk);
    total_clr = 0;
    checks++;
    if (total !== 16'd16 || total_sat !== 0) begin
      errors++;
      $display("FAIL clr_hs got=%0d sat=%b exp=16 sat=0", total, total_sat);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk); total_clr = 1;
    @(negedge clk); total_clr = 0;
    out_ready = 1;
    send(32'hFFFF_FFFF, 0);
    drain();
    checks++;
    if (total6 !== 6'd32 || total_sat6 !== 0) begin
      errors++;
      $display("FAIL sat_first got=%0d sat=%b exp=32 sat=0", total6, total_sat6);
    end
    send(32'hFFFF_FFFF, 0);
    drain();
    checks++;
    if (total6 !== 6'd63 || total_sat6 !== 1) begin
      errors++;
      $display("FAIL sat_second got=%0d sat=%b exp=63 sat=1", total6, total_sat6);
    end
    send(32'h0000_000F, 0);
    drain();
    checks++;
    if (total6 !== 6'd63 || total_sat6 !== 1 || total !== 16'(m16) || total_sat !== s16) begin
      errors++;
      $display("FAIL sat_sticky got=%0d/%b tot16=%0d exp=63/1 tot16=%0d", total6, total_sat6, total, m16);
    end
    @(negedge clk); total_clr = 1;
    @(negedge clk); total_clr = 0;
    checks++;
    if (total6 !== 0 || total_sat6 !== 0 || total !== 0) begin
      errors++;
      $display("FAIL sat_clr got=%0d sat=%b tot16=%0d exp=0", total6, total_sat6, total);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    send(32'h0000_00F0, 0);
    drain();
    send(32'hAAAA_AAAA, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 0;
    #1;
    checks++;
    if (in_ready !== 0 || out_valid !== 0 || dout !== 0 || total !== 0 || total_sat !== 0 || total6 !== 0) begin
      errors++;
      $display("FAIL mid_reset rdy=%b vld=%b dout=%0d tot=%0d sat=%b exp=0", in_ready, out_valid, dout, total, total_sat);
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
    send(32'h0000_00FF, 0);
    drain();
    checks++;
    if (total !== 16'd8) begin
      errors++;
      $display("FAIL after_reset_total got=%0d exp=8", total);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_count_zeros();
    test_backpressure();
    test_total();
    test_saturate();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
